// File: rtl/car_link_pkg.sv
// Shared frame layout and FSM state types for the car status link responder.
package car_link_pkg;
  localparam logic [1:0] LINK_HDR = 2'b10;

  localparam int MOV_LSB     = 0;
  localparam int PLACE_BIT   = 4;
  localparam int DESTROY_BIT = 5;

  localparam int DET_FRONT = 0;
  localparam int DET_LEFT  = 1;
  localparam int DET_RIGHT = 2;
  localparam int DET_BACK  = 3;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter; o_ready also opens on the last stop cycle so a queued
// byte follows with no idle gap.
module uart_byte_tx
  import car_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  tx_state_e      r_state;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_bit;
  logic [7:0]     r_shift;
  logic           r_tx;
  logic           w_bit_end;

  assign w_bit_end = (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign o_ready   = (r_state == TX_IDLE) || ((r_state == TX_STOP) && w_bit_end);
  assign o_busy    = (r_state != TX_IDLE);
  assign o_tx      = r_tx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
      case (r_state)
        TX_IDLE: begin
          r_cnt <= '0;
          if (i_load) begin
            r_state <= TX_START;
            r_shift <= i_data;
            r_tx    <= 1'b0;
          end
        end
        TX_START: if (w_bit_end) begin
          r_state <= TX_DATA;
          r_tx    <= r_shift[0];
          r_shift <= {1'b0, r_shift[7:1]};
          r_bit   <= '0;
        end
        TX_DATA: if (w_bit_end) begin
          if (r_bit == 3'd7) begin
            r_state <= TX_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
          end
        end
        TX_STOP: if (w_bit_end) begin
          if (i_load) begin
            r_state <= TX_START;
            r_shift <= i_data;
            r_tx    <= 1'b0;
          end else begin
            r_state <= TX_IDLE;
            r_tx    <= 1'b1;
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/car_link_responder.sv
// Far-end partner of the device status link: decodes status frames into
// command pulses, answers each with a detector byte, and watches link activity.
module car_link_responder
  import car_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int TIMEOUT_CLKS = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic [3:0] detector_in,
  output logic [3:0] moving_cmd,
  output logic       place_beacon,
  output logic       destroy_beacon,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       link_alive
);
  localparam int RCW = $clog2(CLKS_PER_BIT);
  localparam int WCW = $clog2(TIMEOUT_CLKS + 1);

  rx_state_e       r_rx_state;
  logic            r_rx_s1, r_rx_s2, r_rx_prev;
  logic [RCW-1:0]  r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_shift;
  logic [3:0]      r_moving;
  logic            r_place, r_destroy, r_cmd_valid, r_frame_err;
  logic            r_alive, r_pending;
  logic [WCW-1:0]  r_wd_cnt;

  logic            w_fall, w_rx_half, w_rx_bit_end;
  logic            w_load, w_tx_ready, w_tx_busy;
  logic [7:0]      w_reply;

  // Sync flops and edge history reset low, so a frame already on the line at
  // release is ignored until rx has been seen high and falls again.
  assign w_fall       = r_rx_prev & ~r_rx_s2;
  assign w_rx_half    = (r_rx_cnt == RCW'(CLKS_PER_BIT / 2 - 1));
  assign w_rx_bit_end = (r_rx_cnt == RCW'(CLKS_PER_BIT - 1));

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_rx_s1     <= 1'b0;
      r_rx_s2     <= 1'b0;
      r_rx_prev   <= 1'b0;
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_shift  <= '0;
      r_moving    <= '0;
      r_place     <= 1'b0;
      r_destroy   <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_s1     <= rx;
      r_rx_s2     <= r_rx_s1;
      r_rx_prev   <= r_rx_s2;
      r_place     <= 1'b0;
      r_destroy   <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_rx_state)
        RX_IDLE: if (w_fall) begin
          r_rx_state <= RX_START;
          r_rx_cnt   <= '0;
          r_rx_bit   <= '0;
        end
        RX_START: if (w_rx_half) begin
          r_rx_cnt   <= '0;
          r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        RX_DATA: if (w_rx_bit_end) begin
          r_rx_cnt   <= '0;
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 1'b1;
          if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        RX_STOP: if (w_rx_bit_end) begin
          r_rx_cnt   <= '0;
          r_rx_state <= RX_IDLE;
          if (r_rx_s2 && (r_rx_shift[7:6] == LINK_HDR)) begin
            r_cmd_valid <= 1'b1;
            r_moving    <= r_rx_shift[MOV_LSB +: 4];
            r_place     <= r_rx_shift[PLACE_BIT];
            r_destroy   <= r_rx_shift[DESTROY_BIT];
          end else r_frame_err <= 1'b1;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt <= '0;
      r_alive  <= 1'b0;
    end else if (r_cmd_valid) begin
      r_wd_cnt <= '0;
      r_alive  <= 1'b1;
    end else if (r_wd_cnt != WCW'(TIMEOUT_CLKS)) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
      if (r_wd_cnt == WCW'(TIMEOUT_CLKS - 1)) r_alive <= 1'b0;
    end
  end

  // At most one reply is queued; extra commands while one waits are merged.
  assign w_load = r_cmd_valid | r_pending;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                       r_pending <= 1'b0;
    else if (w_load && w_tx_ready) r_pending <= 1'b0;
    else if (r_cmd_valid && w_tx_busy) r_pending <= 1'b1;
  end

  always_comb begin
    w_reply            = '0;
    w_reply[DET_FRONT] = detector_in[DET_FRONT];
    w_reply[DET_LEFT]  = detector_in[DET_LEFT];
    w_reply[DET_RIGHT] = detector_in[DET_RIGHT];
    w_reply[DET_BACK]  = detector_in[DET_BACK];
  end

  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .i_clk   (sys_clk),
    .i_rst   (rst),
    .i_load  (w_load),
    .i_data  (w_reply),
    .o_ready (w_tx_ready),
    .o_busy  (w_tx_busy),
    .o_tx    (tx)
  );

  assign moving_cmd     = r_moving;
  assign place_beacon   = r_place;
  assign destroy_beacon = r_destroy;
  assign cmd_valid      = r_cmd_valid;
  assign frame_err      = r_frame_err;
  assign link_alive     = r_alive;
endmodule

// File: doc/car_link_responder.md
Name: car_link_responder

Overview:
- Far-end partner of the device's UART status link.
- Receives the device's 8-bit status frame {2'b10, destroy_beacon, place_beacon, moving_state[3:0]} and decodes it into command outputs.
- Answers every accepted frame with a detector byte whose bit positions are bit0 front, bit1 left, bit2 right, bit3 back.
- Used as the on-board/bench stand-in for the simulator, and for loopback tests of the device top.

Parameters:
- CLKS_PER_BIT, 10417, sys_clk cycles per UART bit (100 MHz / 9600 baud).
- TIMEOUT_CLKS, 50_000_000, cycles without an accepted frame before link_alive drops.

Ports:
- sys_clk  in  1  system clock. One clock domain.
- rst  in  1  reset, asynchronous, active-high.
- rx  in  1  serial input, driven by the device tx. Idle high.
- tx  out  1  serial output to the device rx. Idle high.
- detector_in  in  4  {back,right,left,front}, to be reported.
- moving_cmd  out  4  last accepted moving_state nibble.
- place_beacon  out  1  one-cycle pulse, accepted frame bit4=1.
- destroy_beacon  out  1  one-cycle pulse, accepted frame bit5=1.
- cmd_valid  out  1  one-cycle pulse per accepted frame.
- frame_err  out  1  one-cycle pulse on a bad stop bit or a bad header.
- link_alive  out  1  high while frames keep arriving.

Behaviour:
- Reset values (async assert, synchronous release to IDLE): tx=1, moving_cmd=0, all pulses 0, link_alive=0, timeout counter 0, pending=0.
- rx synchronisation: rx passes through a 2-flop synchroniser. All RX timing below refers to the synchronised signal.

RX state machine (IDLE, START, DATA, STOP):
- IDLE: a falling edge moves to START with the bit counter cleared.
- START: at CLKS_PER_BIT/2 (integer divide), sample the line. Low goes to DATA; high is a glitch and returns to IDLE with no error.
- DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
- STOP: sample after CLKS_PER_BIT cycles.
  - Stop=1 and byte[7:6]==2'b10: frame accepted.
  - Stop=0 or a wrong header: frame_err pulses, outputs stay unchanged, RX returns to IDLE.
  - After a stop=0 error, RX waits for the line to return high before arming again.

Frame acceptance, in the cycle after the stop sample:
- moving_cmd<=byte[3:0].
- place_beacon<=byte[4] and destroy_beacon<=byte[5], both one-cycle pulses.
- cmd_valid pulses.
- Both beacon bits set in one frame: both pulse together. No arbitration here.

TX state machine (IDLE, START, DATA, STOP; 10*CLKS_PER_BIT cycles per byte):
- Trigger: cmd_valid with TX IDLE loads {4'b0000, detector_in} on the next cycle and drives the start bit.
- Sampling: detector_in is sampled at load time, not at command time.
- TX busy at cmd_valid: set pending. Further commands while pending=1 are merged, so at most one reply is queued.
- Pending reply: on entering TX IDLE with pending=1, reload immediately (zero idle cycles), clear pending, and sample detector_in then.
- Line state: tx=1 whenever TX is IDLE.

Link watchdog:
- The counter clears on cmd_valid and otherwise increments, saturating at TIMEOUT_CLKS.
- link_alive=1 from the cycle after cmd_valid until the counter reaches TIMEOUT_CLKS.

Reset mid-frame:
- Both FSMs abort immediately and tx returns to 1.
- A partial RX byte is discarded.
- After release, a frame already in progress on rx is not resynchronised until the line has been high and then falls again.

Decomposition:
- Shared package car_link_pkg:
  - LINK_HDR=2'b10.
  - Bit indices MOV_LSB=0, PLACE_BIT=4, DESTROY_BIT=5, DET_FRONT=0, DET_LEFT=1, DET_RIGHT=2, DET_BACK=3.
  - RX and TX state enums.
- Sub-module uart_byte_tx (load/busy handshake, baud counter, shift register).
- RX, decode and watchdog stay inline in car_link_responder.

Test Plan:
1. CLKS_PER_BIT=16. Send byte 8'h83 -> cmd_valid once, moving_cmd=4'h3, no beacon pulses. With detector_in=4'b0101, tx carries byte 8'h05; start bit begins 1 cycle after cmd_valid and lasts 160 cycles in total.
2. Send 8'hB1 -> moving_cmd=4'h1; place_beacon and destroy_beacon pulse in the same cycle as cmd_valid.
3. Send 8'h43 (bad header) -> frame_err pulses, no cmd_valid, moving_cmd unchanged, tx stays 1. Then force stop bit=0 on 8'h82 -> frame_err, RX rearms only after rx returns high.
4. 3-cycle rx low glitch -> no error, no data, RX back in IDLE.
5. Send three frames back-to-back while a reply is transmitting. Change detector_in from 4'h1 to 4'h8 mid-reply -> exactly two replies, the second is 8'h08 and starts with no gap.
6. TIMEOUT_CLKS=1000: one frame, then silence -> link_alive high 1 cycle after cmd_valid, low at 1000 cycles. Assert rst mid-TX -> tx=1 immediately, all outputs at reset values.
